// File: rtl/add_share_pkg.sv
// Shared types and constants for the shared-adder controller.
package add_share_pkg;

  localparam int ADD_LAT  = 2;
  localparam int TAG_ID_W = 3;  // wide enough for up to 8 requesters

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Low bit index of requester idx inside a packed N*w operand bus.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/add_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer
// moves past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [PW-1:0] ptr_q, ptr_d;
  int            cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      if (!grant_vld && en && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = PW'(cand);
        grant_vld   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/add_share_ctrl.sv
// Shares one fixed-latency pipelined adder among N requesters; a tag pipe that
// mirrors the adder latency routes each sum back to its issuer.
module add_share_ctrl
  import add_share_pkg::*;
#(
  parameter int W   = 12,
  parameter int N   = 4,
  parameter int LAT = ADD_LAT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic           add_start,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  input  logic [W-1:0]   add_y,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  op_a [N];
  logic [W-1:0]  op_b [N];
  logic [N-1:0]  eligible, grant;
  logic [PW-1:0] grant_idx;
  logic          grant_vld;

  logic          add_start_q, add_start_d;
  logic [W-1:0]  add_a_q, add_a_d, add_b_q, add_b_d;
  logic [N-1:0]  rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic [N-1:0]  pending_q, pending_d;
  tag_t          tag_q [LAT+1];
  tag_t          tag_d [LAT+1];
  tag_t          tag_last;

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign op_a[gi] = req_a[slice_lo(gi, W) +: W];
    assign op_b[gi] = req_b[slice_lo(gi, W) +: W];
  end

  // A requester with an op in flight is masked until its response is returned.
  assign eligible = req_valid & ~pending_q & {N{en}};

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign tag_last = tag_q[LAT];

  always_comb begin
    add_start_d = grant_vld;
    add_a_d     = grant_vld ? op_a[grant_idx] : add_a_q;
    add_b_d     = grant_vld ? op_b[grant_idx] : add_b_q;
    tag_d[0].valid = grant_vld;
    tag_d[0].id    = grant_vld ? TAG_ID_W'(grant_idx) : '0;
    for (int k = 1; k <= LAT; k++) tag_d[k] = tag_q[k-1];

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    pending_d   = pending_q;
    if (tag_last.valid) rsp_data_d = add_y;
    for (int i = 0; i < N; i++) begin
      if (tag_last.valid && tag_last.id == TAG_ID_W'(i)) begin
        rsp_valid_d[i] = 1'b1;
        pending_d[i]   = 1'b0;
      end
    end
    pending_d = pending_d | grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      pending_q   <= '0;
      for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
    end else begin
      add_start_q <= add_start_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      pending_q   <= pending_d;
      for (int k = 0; k <= LAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign req_ready = grant;
  assign add_start = add_start_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = |pending_q;

endmodule
